led_blink_decoder: RTL and testbench
====================================

# led_blink_decoder

Receive-side counterpart of the variable-period LED blinker: samples a blink waveform (a 1-unit high pulse followed by a low gap, with the period growing 2, 3, …, 10 units and wrapping), measures each high time and rising-to-rising period in whole units, and decodes the step index. Also checks that steps advance in order and reports lock, format errors and loss of signal. Used on the board-test path to self-check the blinker output, or to decode a blink code arriving from another board.

## Interface
- `UNIT`, 50_000_000: clock cycles per time unit (1 s at 50 MHz).
- `TOL`, 1000: accepted deviation in cycles from an exact multiple of `UNIT`; must be < `UNIT`/2.
- `CNT_W`, 29: sub-unit counter width; must satisfy 2^`CNT_W` > `UNIT`.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `led_in`  in  1: blink waveform; asynchronous to `clk`.
- `meas_valid`  out  1: one-cycle pulse when a full period has been measured.
- `on_units`  out  4: high time of the last period, in units.
- `period_units`  out  4: last rising-to-rising period, in units.
- `step`  out  4: `period_units` − 2 (valid range 0..8).
- `fmt_err`  out  1: qualified by `meas_valid`; set when the measurement is out of tolerance or out of range.
- `seq_err`  out  1: qualified by `meas_valid`; set when `step` is not the expected next step.
- `locked`  out  1: level; set while the sequence is being tracked correctly.
- `timeout`  out  1: one-cycle pulse on loss of signal.

## Operation
- `led_in` passes through a 2-flop synchronizer, then a rising/falling edge detector.
- Time measurement:
  - `sub_cnt` counts 0..`UNIT`−1 and wraps.
  - `unit_cnt` (4 bits) increments on each wrap and saturates at 15.
  - Both clear on every rising edge. The high time is captured on the falling edge, and the counters keep running.
- Quantizing a measurement `(u, s)`:
  - If s ≤ `TOL`, the value is u units.
  - Else if s ≥ `UNIT`−`TOL`, the value is u+1 units.
  - Otherwise the measurement is a format error.
- States:
  - IDLE: wait for a rising edge, then go to HIGH.
  - HIGH: on a falling edge, capture the high time and go to LOW.
  - LOW: on a rising edge, evaluate the period, emit `meas_valid`, and go to HIGH.
- Timeout: in HIGH or LOW, if `unit_cnt` reaches 12, pulse `timeout`, clear `locked`, and go to IDLE.
- `fmt_err` is set if any of these hold:
  - the high time or period is untolerable;
  - `on_units` ≠ 1;
  - `period_units` is outside 2..10.
- Sequence check:
  - The expected step is (previous good `step` + 1) mod 9.
  - The first measurement after IDLE or after any error sets the expectation only. It never raises `seq_err`.
- Lock:
  - A good measurement has `fmt_err` = 0 and `seq_err` = 0.
  - 3 consecutive good in-sequence measurements set `locked`.
  - Any `fmt_err`, `seq_err` or `timeout` clears `locked` and resets the good-run counter to 0.
- A glitch shorter than the tolerance window produces `fmt_err`, and decoding restarts from the glitch's rising edge.

## Timing
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - The counters and the expected step are cleared.
  - The synchronizer flops are cleared to 0.
- Latency: a rising edge of `led_in` first sampled at edge k gives `meas_valid` high in cycle k+3 (2 synchronizer cycles + 1 registered evaluation).
- `on_units`, `period_units` and `step` update in the same cycle as `meas_valid` and hold until the next one.
- A measurement and a `timeout` never coincide: a rising edge in the same cycle that `unit_cnt` reaches 12 counts as the edge.
- Reset asserted mid-period discards the partial measurement. Decoding then resumes in IDLE and needs one full period before the first `meas_valid`.
- Edges inside IDLE are not measured: the first rising edge only starts timing.

## Structure
- Package `led_blink_pkg` holds:
  - the state enum (IDLE, HIGH, LOW);
  - constants `MAX_UNITS` = 12, `NUM_STEPS` = 9, `MIN_PERIOD` = 2, `LOCK_RUN` = 3.
- Sub-module `led_sync_edge`: 2-flop synchronizer plus registered `rise`/`fall` pulse outputs, with async active-high reset.

## Test plan
Bench uses `UNIT`=100, `TOL`=4.
- Clean sequence: high 100 / period 200, 300, …, 1000, then 200 → `step` 0..8, 0; `locked` rises on the 3rd valid measurement; no errors.
- Tolerance edges: period 303 → `period_units`=3; period 297 → 3; period 350 → `fmt_err`=1 and `locked`=0.
- Wrong high time: high 200, period 400 → `on_units`=2 and `fmt_err`=1.
- Skipped step: after `locked` with step 2, apply period 600 → `step`=4, `seq_err`=1, `locked`=0; then 700 → good, and counting to relock restarts.
- Loss of signal: hold `led_in` low after a rising edge → `timeout` pulse exactly 12×100 cycles after that edge, state returns to IDLE, `locked`=0.
- Reset mid-LOW: assert `rst` during step 5 → all outputs 0 at once; no `meas_valid` until two rising edges after release.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared types and constants for the LED blink-code decoder.
package led_blink_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  // A quantized time measurement: ok is clear when the raw count falls
  // between two whole units outside the tolerance window.
  typedef struct packed {
    logic       ok;
    logic [3:0] units;
  } qnt_t;

  localparam int MAX_UNITS  = 12;
  localparam int NUM_STEPS  = 9;
  localparam int MIN_PERIOD = 2;
  localparam int LOCK_RUN   = 3;
  localparam int MAX_PERIOD = MIN_PERIOD + NUM_STEPS - 1;

endpackage

// File: rtl/led_blink_decoder_if.sv
// Blink input and decoded-measurement outputs of the blink decoder.
interface led_blink_decoder_if;
  logic       led_in;
  logic       meas_valid;
  logic [3:0] on_units;
  logic [3:0] period_units;
  logic [3:0] step;
  logic       fmt_err;
  logic       seq_err;
  logic       locked;
  logic       timeout;

  // Source of the waveform / consumer of the decoded results
  modport master (
    output led_in,
    input  meas_valid, on_units, period_units, step,
    input  fmt_err, seq_err, locked, timeout
  );

  // The decoder itself
  modport slave (
    input  led_in,
    output meas_valid, on_units, period_units, step,
    output fmt_err, seq_err, locked, timeout
  );
endinterface

// File: rtl/led_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with registered
// single-cycle rise/fall pulses taken from the synchronized level.
module led_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_p0;
  logic sync_p1;
  logic lvl_p2;

  // p0/p1 resolve metastability, p2 holds the previous synchronized level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      lvl_p2  <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      meta_p0 <= din;
      sync_p1 <= meta_p0;
      lvl_p2  <= sync_p1;
      rise    <= sync_p1 & ~lvl_p2;
      fall    <= ~sync_p1 & lvl_p2;
    end
  end

endmodule

// File: rtl/led_blink_decoder.sv
// Blink-code decoder: times each high pulse and rising-to-rising period
// in whole units, decodes the step index, tracks step order and lock, and
// flags format errors and loss of signal.
module led_blink_decoder
  import led_blink_pkg::*;
#(
  parameter int UNIT  = 50_000_000,
  parameter int TOL   = 1000,
  parameter int CNT_W = 29
) (
  input logic                clk,
  input logic                rst,
  led_blink_decoder_if.slave bus
);

  logic rise;
  logic fall;

  led_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.led_in),
    .rise (rise),
    .fall (fall)
  );

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Round a (units, sub-unit) count to whole units when it lies within
  // TOL cycles of a unit boundary on either side.
  function automatic qnt_t quantize(input logic [3:0] u, input logic [CNT_W-1:0] s);
    qnt_t q;
    if (s <= CNT_W'(TOL)) begin
      q.ok    = 1'b1;
      q.units = u;
    end else if (s >= CNT_W'(UNIT - TOL)) begin
      q.ok    = 1'b1;
      q.units = u + 4'd1;
    end else begin
      q.ok    = 1'b0;
      q.units = u;
    end
    return q;
  endfunction

  logic [CNT_W-1:0] sub_cnt;
  logic [3:0]       unit_cnt;

  // Elapsed time since the last rising edge; the edge cycle itself counts
  // as one elapsed cycle so that an N-cycle period reads back as exactly N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_cnt  <= '0;
      unit_cnt <= '0;
    end else if (rise) begin
      sub_cnt  <= CNT_W'(1);
      unit_cnt <= '0;
    end else if (sub_cnt == CNT_W'(UNIT - 1)) begin
      sub_cnt  <= '0;
      unit_cnt <= sat_inc(unit_cnt);
    end else begin
      sub_cnt  <= sub_cnt + CNT_W'(1);
    end
  end

  state_t     state;
  qnt_t       hi_q;
  logic [3:0] exp_step;
  logic       exp_vld;
  logic [1:0] run_cnt;

  logic       meas_valid_r;
  logic [3:0] on_units_r;
  logic [3:0] period_units_r;
  logic [3:0] step_r;
  logic       fmt_err_r;
  logic       seq_err_r;
  logic       locked_r;
  logic       timeout_r;

  qnt_t       cur_q;
  logic [3:0] per_step;
  logic [3:0] next_exp;
  logic       fmt_now;
  logic       seq_now;
  logic       lost;

  // Evaluate the running count as a candidate period against the captured high time
  always_comb begin
    cur_q    = quantize(unit_cnt, sub_cnt);
    per_step = cur_q.units - 4'(MIN_PERIOD);
    fmt_now  = !cur_q.ok || !hi_q.ok || (hi_q.units != 4'd1) ||
               (cur_q.units < 4'(MIN_PERIOD)) || (cur_q.units > 4'(MAX_PERIOD));
    seq_now  = !fmt_now && exp_vld && (per_step != exp_step);
    next_exp = (per_step == 4'(NUM_STEPS - 1)) ? 4'd0 : per_step + 4'd1;
    lost     = (unit_cnt == 4'(MAX_UNITS));
  end

  // Decoder state machine with registered measurement, sequence and lock outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      hi_q           <= '0;
      exp_step       <= '0;
      exp_vld        <= 1'b0;
      run_cnt        <= '0;
      meas_valid_r   <= 1'b0;
      on_units_r     <= '0;
      period_units_r <= '0;
      step_r         <= '0;
      fmt_err_r      <= 1'b0;
      seq_err_r      <= 1'b0;
      locked_r       <= 1'b0;
      timeout_r      <= 1'b0;
    end else begin
      meas_valid_r <= 1'b0;
      timeout_r    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            hi_q  <= cur_q;
            state <= LOW;
          end else if (lost) begin
            timeout_r <= 1'b1;
            locked_r  <= 1'b0;
            run_cnt   <= '0;
            exp_vld   <= 1'b0;
            state     <= IDLE;
          end
        end
        LOW: begin
          if (rise) begin
            meas_valid_r   <= 1'b1;
            on_units_r     <= hi_q.units;
            period_units_r <= cur_q.units;
            step_r         <= per_step;
            fmt_err_r      <= fmt_now;
            seq_err_r      <= seq_now;
            if (!fmt_now && !seq_now) begin
              exp_step <= next_exp;
              exp_vld  <= 1'b1;
              if (run_cnt != 2'(LOCK_RUN)) run_cnt <= run_cnt + 2'd1;
              locked_r <= (run_cnt >= 2'(LOCK_RUN - 1));
            end else begin
              exp_vld  <= 1'b0;
              run_cnt  <= '0;
              locked_r <= 1'b0;
            end
            state <= HIGH;
          end else if (lost) begin
            timeout_r <= 1'b1;
            locked_r  <= 1'b0;
            run_cnt   <= '0;
            exp_vld   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.meas_valid   = meas_valid_r;
  assign bus.on_units     = on_units_r;
  assign bus.period_units = period_units_r;
  assign bus.step         = step_r;
  assign bus.fmt_err      = fmt_err_r;
  assign bus.seq_err      = seq_err_r;
  assign bus.locked       = locked_r;
  assign bus.timeout      = timeout_r;

endmodule

// File: tb/tb_led_blink_decoder.sv
// Bench for led_blink_decoder with UNIT=100, TOL=4: directed blink
// waveforms, an edge-time reference model and per-cycle output compare.
module tb_led_blink_decoder;

  localparam int UNIT_TB = 100;
  localparam int TOL_TB  = 4;
  localparam int LAT     = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic led = 1'b0;

  always #5 clk = ~clk;

  led_blink_decoder_if bus ();
  assign bus.led_in = led;

  led_blink_decoder #(.UNIT(UNIT_TB), .TOL(TOL_TB), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [16:0] outs();
    return {bus.meas_valid, bus.on_units, bus.period_units, bus.step,
            bus.fmt_err, bus.seq_err, bus.locked, bus.timeout};
  endfunction

  // ---------------- reference model: works on edge times ----------------
  typedef struct {
    int due; int on; int per; int step; int fmt; int seq; int locked;
  } mrec_t;
  mrec_t mq[$];
  int    tq[$];

  int m_state = 0;  // 0 waiting for first edge, 1 high, 2 low
  int r_cyc, f_cyc, prev_led;
  int expv, exps, run;

  function automatic void qz(input int c, output int ok, output int u);
    int q  = c / UNIT_TB;
    int rm = c % UNIT_TB;
    if (rm <= TOL_TB) begin ok = 1; u = q; end
    else if (rm >= UNIT_TB - TOL_TB) begin ok = 1; u = q + 1; end
    else begin ok = 0; u = q; end
  endfunction

  always @(posedge clk) begin
    int s, rs, fl, pok, pu, hok, hu, fmt, st, seq, lk;
    mrec_t r;
    cyc++;
    if (rst) begin
      m_state = 0; prev_led = 0; expv = 0; run = 0;
      mq.delete(); tq.delete();
    end else begin
      s  = int'(led);
      rs = (s == 1 && prev_led == 0) ? 1 : 0;
      fl = (s == 0 && prev_led == 1) ? 1 : 0;
      prev_led = s;
      // no edge within 12 units of the last rise: signal lost
      if (m_state != 0 && cyc == r_cyc + 12 * UNIT_TB + 1) begin
        tq.push_back(cyc + 2);
        m_state = 0; expv = 0; run = 0;
      end
      case (m_state)
        0: if (rs) begin r_cyc = cyc; m_state = 1; end
        1: if (fl) begin f_cyc = cyc; m_state = 2; end
        default: if (rs) begin
          qz(cyc - r_cyc, pok, pu);
          qz(f_cyc - r_cyc, hok, hu);
          fmt = (!pok || !hok || hu != 1 || pu < 2 || pu > 10) ? 1 : 0;
          st  = (pu - 2) & 15;
          seq = (!fmt && expv && st != exps) ? 1 : 0;
          if (!fmt && !seq) begin
            exps = (st + 1) % 9; expv = 1;
            if (run < 3) run++;
            lk = (run >= 3) ? 1 : 0;
          end else begin
            expv = 0; run = 0; lk = 0;
          end
          r = '{due: cyc + LAT, on: hu & 15, per: pu & 15, step: st, fmt: fmt, seq: seq, locked: lk};
          mq.push_back(r);
          r_cyc = cyc; m_state = 1;
        end
      endcase
    end
  end

  // ---------------- compare process (opposite clock edge) ----------------
  typedef struct { int on; int per; int step; int fmt; int seq; int locked; } obs_t;
  obs_t obs[$];
  int   to_cyc = -1;
  int   cur_locked = 0;
  mrec_t e;

  always @(negedge clk) begin
    int exp_mv, exp_to;
    obs_t o;
    if (rst) begin
      cur_locked = 0;
      chk("reset_outputs", 32'(outs()), 0);
    end else begin
      exp_mv = 0; exp_to = 0;
      if (mq.size() > 0 && mq[0].due == cyc) begin exp_mv = 1; e = mq.pop_front(); end
      if (tq.size() > 0 && tq[0] == cyc) begin exp_to = 1; void'(tq.pop_front()); cur_locked = 0; end
      chk("meas_valid", 32'(bus.meas_valid), exp_mv);
      if (exp_mv == 1) begin
        chk("on_units", 32'(bus.on_units), e.on);
        chk("period_units", 32'(bus.period_units), e.per);
        chk("step", 32'(bus.step), e.step);
        chk("fmt_err", 32'(bus.fmt_err), e.fmt);
        chk("seq_err", 32'(bus.seq_err), e.seq);
        cur_locked = e.locked;
      end
      chk("timeout", 32'(bus.timeout), exp_to);
      chk("locked", 32'(bus.locked), cur_locked);
      if (bus.meas_valid) begin
        o = '{on: int'(bus.on_units), per: int'(bus.period_units), step: int'(bus.step),
              fmt: int'(bus.fmt_err), seq: int'(bus.seq_err), locked: int'(bus.locked)};
        obs.push_back(o);
      end
      if (bus.timeout) to_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input int h, input int p, output int st);
    for (int i = 0; i < p; i++) begin
      @(posedge clk); #2;
      if (i == 0) st = cyc;
      led = (i < h);
    end
  endtask

  // fld: 0 on_units, 1 period_units, 2 step, 3 fmt_err, 4 seq_err, 5 locked
  task automatic lit(input string nm, input int idx, input int fld, input int exp);
    int v;
    v = -1;
    if (idx < obs.size()) begin
      case (fld)
        0: v = obs[idx].on;
        1: v = obs[idx].per;
        2: v = obs[idx].step;
        3: v = obs[idx].fmt;
        4: v = obs[idx].seq;
        default: v = obs[idx].locked;
      endcase
    end
    chk(nm, v, exp);
  endtask

  int ph1_h[28] = '{100,100,100,100,100,100,100,100,100,100,100,100,100,100,
                    100,100,100,100,100,100,100,200,100,100,100,  3,100,100};
  int ph1_p[28] = '{200,300,400,500,600,700,800,900,1000,200,297,400,600,700,
                    800,900,1000,200,303,350,400,400,305,296,150,200,300,1300};
  int ph2_p[5]  = '{200,300,400,500,600};

  initial begin
    int st, n_before;
    rst = 1'b1; led = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_zero", 32'(outs()), 0);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) pulse(ph1_h[i], ph1_p[i], st);
    // st now holds the drive cycle of the pulse left to time out
    lit("clean_m0_per", 0, 1, 2);
    lit("clean_m0_step", 0, 2, 0);
    lit("clean_m1_unlocked", 1, 5, 0);
    lit("clean_m2_locked", 2, 5, 1);
    lit("clean_m8_step", 8, 2, 8);
    lit("wrap_m9_step", 9, 2, 0);
    lit("wrap_m9_seq", 9, 4, 0);
    lit("tol297_per", 10, 1, 3);
    lit("skip_step", 12, 2, 4);
    lit("skip_seq_err", 12, 4, 1);
    lit("skip_unlocked", 12, 5, 0);
    lit("after_skip_seq", 13, 4, 0);
    lit("after_skip_unlocked", 14, 5, 0);
    lit("relock", 15, 5, 1);
    lit("tol303_per", 18, 1, 3);
    lit("tol350_fmt", 19, 3, 1);
    lit("tol350_unlocked", 19, 5, 0);
    lit("wrong_high_on", 21, 0, 2);
    lit("wrong_high_fmt", 21, 3, 1);
    lit("tol305_fmt", 22, 3, 1);
    lit("tol296_per", 23, 1, 3);
    lit("tol296_fmt", 23, 3, 0);
    lit("glitch_fmt", 25, 3, 1);
    chk("timeout_latency", to_cyc - (st + 1 + LAT), 12 * UNIT_TB);
    chk("timeout_unlocked", 32'(bus.locked), 0);

    for (int i = 0; i < 5; i++) pulse(100, ph2_p[i], st);
    lit("post_timeout_step", 27, 2, 0);
    lit("post_timeout_seq", 27, 4, 0);

    // step-5 period interrupted by reset while low
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      led = (i < 100);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", 32'(outs()), 0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    n_before = obs.size();
    repeat (100) @(posedge clk);
    pulse(100, 800, st);
    chk("no_meas_after_1st_rise", obs.size(), n_before);
    pulse(100, 900, st);
    chk("meas_after_2nd_rise", obs.size(), n_before + 1);
    lit("resume_per", n_before, 1, 8);
    lit("resume_seq", n_before, 4, 0);
    pulse(100, 200, st);
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of stimulus, expected finish before 1000000 ns");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
